decoder_scan_ctrl: RTL

Sequencer that sits directly upstream of the 3-to-8 line decoder and drives its address and enable inputs.
- Steps through the enabled lines of an 8-bit mask.
- Holds each line active for a programmable dwell time.
- Inserts one break-before-make guard cycle, with enable low, between lines.
- Runs a single pass or loops continuously; start/stop control, busy/done status.

---
 rtl/decoder_scan_ctrl_pkg.sv | 14 +
 rtl/decoder_scan_ctrl_if.sv | 44 ++++
 rtl/decoder_scan_ctrl_scan_next_sel.sv | 43 ++++
 rtl/decoder_scan_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM state encoding
// and the fixed decoder geometry (3 address bits, 8 lines).
package decoder_scan_ctrl_pkg;

    localparam int SEL_W = 3;
    localparam int LINES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between the scan sequencer and its host.
// The master side drives the requests and configuration; the slave side
// (the sequencer) drives the decoder address/enable and the status flags.
// When DECODER_SCAN_PASS_CNT_EN is defined the bundle also carries pass_cnt.
interface decoder_scan_ctrl_if
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) ();

    logic               start;
    logic               stop;
    logic               continuous;
    logic [LINES-1:0]   mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               en;
    logic               busy;
    logic               done;
`ifdef DECODER_SCAN_PASS_CNT_EN
    logic [7:0]         pass_cnt;

    modport master (
        output start, stop, continuous, mask, dwell,
        input  sel, en, busy, done, pass_cnt
    );

    modport slave (
        input  start, stop, continuous, mask, dwell,
        output sel, en, busy, done, pass_cnt
    );
`else
    modport master (
        output start, stop, continuous, mask, dwell,
        input  sel, en, busy, done
    );

    modport slave (
        input  start, stop, continuous, mask, dwell,
        output sel, en, busy, done
    );
`endif

endinterface

// File: rtl/decoder_scan_ctrl_scan_next_sel.sv
// Combinational line search over an 8-bit mask: finds the lowest set bit
// and the next set bit strictly above the current line, wrapping to the
// lowest set bit when nothing lies above. o_wrap flags that wrap, which is
// also how the sequencer recognises the last line of a pass.
module scan_next_sel
    import decoder_scan_ctrl_pkg::*;
(
    input  logic [LINES-1:0] i_mask,
    input  logic [SEL_W-1:0] i_cur,
    output logic [SEL_W-1:0] o_nxt,
    output logic             o_wrap,
    output logic [SEL_W-1:0] o_first
);

    logic [SEL_W-1:0] w_above;
    logic             w_found;

    // Lowest set bit: scan downwards so the smallest index is written last
    always_comb begin
        o_first = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_first = SEL_W'(i);
            end
        end
    end

    // Lowest set bit strictly above the current line, if any
    always_comb begin
        w_above = '0;
        w_found = 1'b0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (i_mask[i] && (SEL_W'(i) > i_cur)) begin
                w_above = SEL_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign o_nxt  = w_found ? w_above : o_first;
    assign o_wrap = ~w_found;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving the address/enable of a 3-to-8 line decoder.
// Visits each enabled mask line for dwell+1 cycles, separated by a single
// enable-low guard cycle so the address never moves while enable is high.
// Optional feature macro: DECODER_SCAN_PASS_CNT_EN adds an 8-bit pass counter.
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_scan_ctrl_if.slave  bus
);

    state_t             r_state, w_stateNext;
    logic [SEL_W-1:0]   r_sel, w_selNext;
    logic               r_en, w_enNext;
    logic               r_busy, w_busyNext;
    logic               r_done, w_doneNext;
    logic [DWELL_W-1:0] r_cnt, w_cntNext;
    logic [DWELL_W-1:0] r_dwell, w_dwellNext;
    logic [LINES-1:0]   r_mask, w_maskNext;
    logic               r_cont, w_contNext;
`ifdef DECODER_SCAN_PASS_CNT_EN
    logic [7:0]         r_passCnt, w_passCntNext;
`endif

    logic [LINES-1:0]   w_searchMask;
    logic [SEL_W-1:0]   w_nxt;
    logic [SEL_W-1:0]   w_first;
    logic               w_wrap;
    logic               w_startOk;

    // In IDLE the search looks at the live mask to pick the first line;
    // once running it only ever sees the latched copy
    assign w_searchMask = (r_state == IDLE) ? bus.mask : r_mask;
    assign w_startOk    = bus.start && !bus.stop && (bus.mask != '0);

    scan_next_sel u_nextSel (
        .i_mask  (w_searchMask),
        .i_cur   (r_sel),
        .o_nxt   (w_nxt),
        .o_wrap  (w_wrap),
        .o_first (w_first)
    );

    // Next-state and next-output decode; everything holds unless a state says otherwise
    always_comb begin
        w_stateNext = r_state;
        w_selNext   = r_sel;
        w_enNext    = r_en;
        w_busyNext  = r_busy;
        w_doneNext  = 1'b0;
        w_cntNext   = r_cnt;
        w_dwellNext = r_dwell;
        w_maskNext  = r_mask;
        w_contNext  = r_cont;
`ifdef DECODER_SCAN_PASS_CNT_EN
        w_passCntNext = r_passCnt;
`endif
        case (r_state)
            IDLE: begin
                w_enNext   = 1'b0;
                w_busyNext = 1'b0;
                if (w_startOk) begin
                    w_maskNext  = bus.mask;
                    w_dwellNext = bus.dwell;
                    w_contNext  = bus.continuous;
                    w_selNext   = w_first;
                    w_cntNext   = bus.dwell;
                    w_enNext    = 1'b1;
                    w_busyNext  = 1'b1;
                    w_stateNext = SCAN;
`ifdef DECODER_SCAN_PASS_CNT_EN
                    w_passCntNext = '0;
`endif
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    w_enNext    = 1'b0;
                    w_busyNext  = 1'b0;
                    w_stateNext = IDLE;
                end else if (r_cnt != '0) begin
                    w_cntNext = r_cnt - 1'b1;
                end else begin
`ifdef DECODER_SCAN_PASS_CNT_EN
                    if (w_wrap) begin
                        w_passCntNext = r_passCnt + 8'd1;
                    end
`endif
                    w_enNext = 1'b0;
                    if (!w_wrap || r_cont) begin
                        w_selNext   = w_nxt;
                        w_stateNext = GUARD;
                    end else begin
                        w_busyNext  = 1'b0;
                        w_doneNext  = 1'b1;
                        w_stateNext = IDLE;
                    end
                end
            end
            GUARD: begin
                if (bus.stop) begin
                    w_enNext    = 1'b0;
                    w_busyNext  = 1'b0;
                    w_stateNext = IDLE;
                end else begin
                    w_cntNext   = r_dwell;
                    w_enNext    = 1'b1;
                    w_stateNext = SCAN;
                end
            end
            default: begin
                w_enNext    = 1'b0;
                w_busyNext  = 1'b0;
                w_stateNext = IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_mask  <= '0;
            r_cont  <= 1'b0;
`ifdef DECODER_SCAN_PASS_CNT_EN
            r_passCnt <= '0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_sel   <= w_selNext;
            r_en    <= w_enNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
            r_cnt   <= w_cntNext;
            r_dwell <= w_dwellNext;
            r_mask  <= w_maskNext;
            r_cont  <= w_contNext;
`ifdef DECODER_SCAN_PASS_CNT_EN
            r_passCnt <= w_passCntNext;
`endif
        end
    end

    assign bus.sel  = r_sel;
    assign bus.en   = r_en;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
`ifdef DECODER_SCAN_PASS_CNT_EN
    assign bus.pass_cnt = r_passCnt;
`endif

endmodule
